// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : btn_pulse_gen
// Description : Synchronises and debounces a raw push-button, emitting one
//               single-cycle enable pulse per press with optional auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_pulse_gen #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_out,
    output logic btn_level,
    output logic repeat_active
);

    localparam int c_DB_W   = $clog2(STABLE_CYCLES);
    localparam int c_TMR_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TMR_W  = $clog2(c_TMR_MX);

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(STABLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DELAY_LAST  = c_TMR_W'(REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_LAST = c_TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic               r_s1;
    logic               r_s2;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic               r_level;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;

    logic w_mismatch;
    logic w_db_done;
    logic w_rise;
    logic w_fall;

    assign w_mismatch = r_s2 ^ r_level;
    assign w_db_done  = w_mismatch && (r_db_cnt == c_DB_LAST);
    assign w_rise     = w_db_done && !r_level;
    assign w_fall     = w_db_done && r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            // Any return to the current level restarts the stability count.
            if (!w_mismatch || w_db_done) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_db_done) begin
                r_level <= ~r_level;
            end
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = ST_HELD;
                    w_pulse_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else if ((REPEAT_EN != 0) && (r_timer == c_DELAY_LAST)) begin
                    w_state_nxt = ST_REPEAT;
                    w_timer_nxt = '0;
                    w_pulse_nxt = 1'b1;
                end else if (r_timer != c_DELAY_LAST) begin
                    // Saturates when repeat is disabled so the timer never wraps.
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_REPEAT: begin
                // Release wins over a repeat pulse due on the same edge.
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_PERIOD_LAST) begin
                    w_timer_nxt = '0;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign pulse_out     = r_pulse;
    assign btn_level     = r_level;
    assign repeat_active = (r_state == ST_REPEAT);

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_pulse_gen
// Description : Bench for btn_pulse_gen; expected pulse edges are queued when a
//               press is driven and matched against pulses as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

    localparam int STABLE = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    logic clk;
    logic reset;
    logic btn_in;
    logic pulse0, level0, rep0;
    logic pulse1, level1, rep1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int q0[$];
    int q1[$];

    btn_pulse_gen #(
        .STABLE_CYCLES(STABLE), .REPEAT_EN(0), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut0 (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .pulse_out(pulse0), .btn_level(level0), .repeat_active(rep0)
    );

    btn_pulse_gen #(
        .STABLE_CYCLES(STABLE), .REPEAT_EN(1), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut1 (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .pulse_out(pulse1), .btn_level(level1), .repeat_active(rep1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse scoreboard: each queue holds the edge numbers at which a pulse is due.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0] < cyc) begin
            vectors++; miscompares++;
            $display("FAIL pulse0_missed: got none expected pulse at edge %0d (now %0d)", q0[0], cyc);
            void'(q0.pop_front());
        end
        if (pulse0) begin
            vectors++;
            if (q0.size() > 0 && q0[0] == cyc) void'(q0.pop_front());
            else begin
                miscompares++;
                $display("FAIL pulse0_unexpected: got pulse at edge %0d expected %0d", cyc,
                         (q0.size() > 0) ? q0[0] : -1);
            end
        end
        if (q1.size() > 0 && q1[0] < cyc) begin
            vectors++; miscompares++;
            $display("FAIL pulse1_missed: got none expected pulse at edge %0d (now %0d)", q1[0], cyc);
            void'(q1.pop_front());
        end
        if (pulse1) begin
            vectors++;
            if (q1.size() > 0 && q1[0] == cyc) void'(q1.pop_front());
            else begin
                miscompares++;
                $display("FAIL pulse1_unexpected: got pulse at edge %0d expected %0d", cyc,
                         (q1.size() > 0) ? q1[0] : -1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // Press pulse at edge p; repeat pulses (dut1 only) strictly before edge stop.
    function automatic void push_press(input int p, input int stop);
        q0.push_back(p);
        q1.push_back(p);
        for (int t = p + DELAY; t < stop; t += PERIOD) q1.push_back(t);
    endfunction

    task automatic test_reset();
        reset = 1'b1; btn_in = 1'b0;
        tick(); tick();
        vectors++;
        if ({pulse0, level0, rep0, pulse1, level1, rep1} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000", {pulse0, level0, rep0, pulse1, level1, rep1});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({pulse0, level0, rep0, pulse1, level1, rep1} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_release_outputs: got %b expected 000000", {pulse0, level0, rep0, pulse1, level1, rep1});
        end
    endtask

    task automatic test_clean_press();
        int c, p, d;
        c = cyc; p = c + STABLE + 2; d = c + 30;
        btn_in = 1'b1;
        push_press(p, d + STABLE + 2);
        wait_cyc(p - 1);
        vectors++;
        if (level0 !== 1'b0) begin miscompares++; $display("FAIL press_level_early: got %b expected 0", level0); end
        tick();
        vectors++;
        if (level0 !== 1'b1) begin miscompares++; $display("FAIL press_level_rise: got %b expected 1", level0); end
        vectors++;
        if (level1 !== 1'b1) begin miscompares++; $display("FAIL press_level1_rise: got %b expected 1", level1); end
        wait_cyc(p + DELAY - 1);
        vectors++;
        if (rep1 !== 1'b0) begin miscompares++; $display("FAIL repeat_active_early: got %b expected 0", rep1); end
        tick();
        vectors++;
        if (rep1 !== 1'b1) begin miscompares++; $display("FAIL repeat_active_start: got %b expected 1", rep1); end
        vectors++;
        if (rep0 !== 1'b0) begin miscompares++; $display("FAIL repeat_active_disabled: got %b expected 0", rep0); end
        wait_cyc(d);
        btn_in = 1'b0;
        wait_cyc(d + STABLE + 1);
        vectors++;
        if ({level0, rep1} !== 2'b11) begin miscompares++; $display("FAIL release_early: got %b expected 11", {level0, rep1}); end
        tick();
        vectors++;
        if ({level0, rep1} !== 2'b00) begin miscompares++; $display("FAIL release_fall: got %b expected 00", {level0, rep1}); end
        wait_cyc(d + 10);
        vectors++;
        if (q0.size() + q1.size() != 0) begin miscompares++; $display("FAIL clean_press_pending: got %0d expected 0", q0.size() + q1.size()); end
    endtask

    task automatic test_bounce();
        bit pat [8];
        int c2, seen;
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            btn_in = pat[i % 8];
            tick();
            if (level0 || level1) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL bounce_level: got %0d high cycles expected 0", seen); end
        c2 = cyc;
        btn_in = 1'b1;
        push_press(c2 + STABLE + 2, c2 + 12 + STABLE + 2);
        wait_cyc(c2 + STABLE + 1);
        vectors++;
        if (level0 !== 1'b0) begin miscompares++; $display("FAIL bounce_steady_early: got %b expected 0", level0); end
        tick();
        vectors++;
        if (level0 !== 1'b1) begin miscompares++; $display("FAIL bounce_steady_rise: got %b expected 1", level0); end
        wait_cyc(c2 + 12);
        btn_in = 1'b0;
        wait_cyc(c2 + 24);
        vectors++;
        if (q0.size() + q1.size() != 0) begin miscompares++; $display("FAIL bounce_pending: got %0d expected 0", q0.size() + q1.size()); end
    endtask

    task automatic test_release_race();
        int c, p;
        c = cyc; p = c + STABLE + 2;
        btn_in = 1'b1;
        push_press(p, p + DELAY + PERIOD);
        // Release so the falling toggle lands on the second repeat edge.
        wait_cyc(p + DELAY + PERIOD - STABLE - 2);
        btn_in = 1'b0;
        wait_cyc(p + DELAY + PERIOD - 1);
        vectors++;
        if (rep1 !== 1'b1) begin miscompares++; $display("FAIL race_active_before: got %b expected 1", rep1); end
        tick();
        vectors++;
        if ({rep1, level1} !== 2'b00) begin miscompares++; $display("FAIL race_after_release: got %b expected 00", {rep1, level1}); end
        wait_cyc(p + DELAY + PERIOD + 8);
        vectors++;
        if (q0.size() + q1.size() != 0) begin miscompares++; $display("FAIL race_pending: got %0d expected 0", q0.size() + q1.size()); end
    endtask

    task automatic test_reset_mid_hold();
        int c, p, d, p2, r;
        c = cyc; p = c + STABLE + 2;
        btn_in = 1'b1;
        push_press(p, p + 15);
        wait_cyc(p + 14);
        reset = 1'b1;
        tick();
        vectors++;
        if ({pulse0, level0, rep0, pulse1, level1, rep1} !== 6'b0) begin
            miscompares++;
            $display("FAIL midhold_reset1: got %b expected 000000", {pulse0, level0, rep0, pulse1, level1, rep1});
        end
        tick();
        vectors++;
        if ({pulse0, level0, rep0, pulse1, level1, rep1} !== 6'b0) begin
            miscompares++;
            $display("FAIL midhold_reset2: got %b expected 000000", {pulse0, level0, rep0, pulse1, level1, rep1});
        end
        reset = 1'b0;
        d = cyc; p2 = d + STABLE + 2; r = p2 + 20;
        push_press(p2, r + STABLE + 2);
        tick();
        vectors++;
        if ({pulse1, level1, rep1} !== 3'b0) begin miscompares++; $display("FAIL midhold_first_cycle: got %b expected 000", {pulse1, level1, rep1}); end
        wait_cyc(p2 - 1);
        vectors++;
        if (level1 !== 1'b0) begin miscompares++; $display("FAIL midhold_level_early: got %b expected 0", level1); end
        tick();
        vectors++;
        if (level1 !== 1'b1) begin miscompares++; $display("FAIL midhold_level_rise: got %b expected 1", level1); end
        wait_cyc(p2 + DELAY - 1);
        vectors++;
        if (rep1 !== 1'b0) begin miscompares++; $display("FAIL midhold_delay_restart: got %b expected 0", rep1); end
        tick();
        vectors++;
        if (rep1 !== 1'b1) begin miscompares++; $display("FAIL midhold_repeat_start: got %b expected 1", rep1); end
        wait_cyc(r);
        btn_in = 1'b0;
        wait_cyc(r + 10);
        vectors++;
        if (q0.size() + q1.size() != 0) begin miscompares++; $display("FAIL midhold_pending: got %0d expected 0", q0.size() + q1.size()); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ctr, exp;
        int c;
        ctr = 4'd0;
        for (int i = 0; i < 17; i++) begin
            c = cyc;
            btn_in = 1'b1;
            push_press(c + STABLE + 2, c + 8 + STABLE + 2);
            while (cyc < c + 16) begin
                if (cyc == c + 8) btn_in = 1'b0;
                tick();
                if (pulse0) ctr = ctr + 4'd1;
            end
            exp = 4'(i + 1);
            vectors++;
            if (ctr !== exp) begin miscompares++; $display("FAIL counter_press%0d: got %0d expected %0d", i, ctr, exp); end
        end
        wait_cyc(cyc + 4);
        vectors++;
        if (q0.size() + q1.size() != 0) begin miscompares++; $display("FAIL counter_pending: got %0d expected 0", q0.size() + q1.size()); end
    endtask

    initial begin
        reset = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_race();
        test_reset_mid_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
